// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// Holds the receiver FSM states, register addresses and STATUS bit positions.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

   // Receiver frame states
`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } rx_state_e;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd4
   } rx_state_e;
`endif

   // Avalon register addresses
   localparam logic [1:0] ADDR_RXDATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS   = 2'd1;
   localparam logic [1:0] ADDR_BAUD_DIV = 2'd2;
   localparam logic [1:0] ADDR_CTRL     = 2'd3;

   // STATUS register bit positions
   localparam int STAT_NOT_EMPTY  = 0;
   localparam int STAT_FULL       = 1;
   localparam int STAT_OVERRUN    = 2;
   localparam int STAT_FRAME_ERR  = 3;
   localparam int STAT_PARITY_ERR = 4;
   localparam int STAT_W          = 5;

   // Oversampling: ticks per bit, the mid-bit tick of the start bit and the last tick of a bit
   localparam int         OVERSAMPLE = 16;
   localparam logic [3:0] TICK_MID   = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0] TICK_LAST  = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO holding received bytes; wrap bit on each pointer separates full from empty.
// Latency: a pushed entry is visible (empty low, dout valid) one cycle after the push edge.
// Backpressure: push while full is ignored unless a pop happens in the same cycle; pop while empty is ignored.
module uart_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   // Same index with differing wrap bits means the writer has lapped the reader
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer advance and storage update
   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
      mem_d    = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q[AW-1:0]] = din;
      end
   end

   // Pointer registers; reset empties the FIFO
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage has no reset; contents are only read behind a valid pointer
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver with 8-entry RX FIFO behind a 2-bit Avalon-MM slave; UART_RX_PARITY_EN adds an even-parity bit.
// Latency: readdata registered, 1 cycle after the sampled read; byte visible in STATUS 1 cycle after stop sample.
// Backpressure: none on the bus (no wait states); bytes arriving with the FIFO full are dropped and flag overrun.
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter logic [15:0] BAUD_DIV_RST = 16'd26,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rxd,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq
);

   // Synchroniser and edge detector
   logic rx_meta_q, rx_meta_d;
   logic rx_sync_q, rx_sync_d;
   logic rx_prev_q, rx_prev_d;

   // Baud tick generator
   logic [15:0] baud_cnt_q, baud_cnt_d;
   logic [15:0] baud_reload;
   logic        tick;

   // Receiver FSM
   rx_state_e   state_q, state_d;
   logic [3:0]  phase_q, phase_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        restart;
   logic        rx_push;
   logic        frame_set;
   logic        parity_set;

   // Registers
   logic [15:0] baud_div_q, baud_div_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic        overrun_q, overrun_d;
   logic        frame_err_q, frame_err_d;
   logic        parity_err_q, parity_err_d;
   logic [31:0] readdata_q, readdata_d;
   logic [STAT_W-1:0] status;

   // Bus decode
   logic rd_en;
   logic wr_en;
   logic pop;
   logic flag_clr;
   logic overrun_set;
   logic unused_wdata;

   // FIFO
   logic [7:0] fifo_dout;
   logic       fifo_full;
   logic       fifo_empty;

   assign rd_en        = chipselect & ~read_n;
   assign wr_en        = chipselect & ~write_n;
   assign pop          = rd_en & (address == ADDR_RXDATA);
   assign flag_clr     = wr_en & (address == ADDR_CTRL);
   assign unused_wdata = ^writedata[31:16];

   // A push into a full FIFO only succeeds if a pop frees a slot in the same cycle
   assign overrun_set  = rx_push & fifo_full & ~pop;

   // Two-flop synchroniser for rxd plus a delayed copy for falling-edge detection
   always_comb begin
      rx_meta_d = rxd;
      rx_sync_d = rx_meta_q;
      rx_prev_d = rx_sync_q;
   end

   // Divisor 0 is treated as 1; the counter restarts on a detected start edge to centre sampling
   always_comb begin
      baud_reload = (baud_div_q == 16'd0) ? 16'd1 : baud_div_q;
      tick        = (baud_cnt_q == 16'd0);
      if (restart || tick) begin
         baud_cnt_d = baud_reload;
      end else begin
         baud_cnt_d = baud_cnt_q - 16'd1;
      end
   end

   // Frame sequencing: start check at mid start bit, then one sample every OVERSAMPLE ticks
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      restart    = 1'b0;
      rx_push    = 1'b0;
      frame_set  = 1'b0;
      parity_set = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (rx_prev_q && !rx_sync_q) begin
               state_d = S_START;
               phase_d = 4'd0;
               restart = 1'b1;
            end
         end
         S_START: begin
            if (tick) begin
               if (phase_q == TICK_MID) begin
                  phase_d   = 4'd0;
                  bit_cnt_d = 3'd0;
                  // Line back high at mid start bit means a glitch, not a frame
                  state_d   = rx_sync_q ? S_IDLE : S_DATA;
               end else begin
                  phase_d = phase_q + 4'd1;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (phase_q == TICK_LAST) begin
                  phase_d   = 4'd0;
                  shift_d   = {rx_sync_q, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_d = S_PARITY;
`else
                     state_d = S_STOP;
`endif
                  end
               end else begin
                  phase_d = phase_q + 4'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (tick) begin
               if (phase_q == TICK_LAST) begin
                  phase_d    = 4'd0;
                  // Even parity: data ones plus parity bit must be even
                  parity_set = rx_sync_q ^ (^shift_q);
                  state_d    = S_STOP;
               end else begin
                  phase_d = phase_q + 4'd1;
               end
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               if (phase_q == TICK_LAST) begin
                  phase_d   = 4'd0;
                  rx_push   = 1'b1;
                  frame_set = ~rx_sync_q;
                  state_d   = S_IDLE;
               end else begin
                  phase_d = phase_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Register writes, sticky error flags (a new error wins over a same-cycle clear)
   always_comb begin
      baud_div_d   = baud_div_q;
      ctrl_d       = ctrl_q;
      overrun_d    = overrun_q;
      frame_err_d  = frame_err_q;
      parity_err_d = parity_err_q;
      if (wr_en && (address == ADDR_BAUD_DIV)) begin
         baud_div_d = writedata[15:0];
      end
      if (flag_clr) begin
         ctrl_d       = writedata[1:0];
         overrun_d    = 1'b0;
         frame_err_d  = 1'b0;
         parity_err_d = 1'b0;
      end
      if (overrun_set) begin
         overrun_d = 1'b1;
      end
      if (frame_set) begin
         frame_err_d = 1'b1;
      end
      if (parity_set) begin
         parity_err_d = 1'b1;
      end
   end

   // STATUS view of FIFO and error state
   always_comb begin
      status                  = '0;
      status[STAT_NOT_EMPTY]  = ~fifo_empty;
      status[STAT_FULL]       = fifo_full;
      status[STAT_OVERRUN]    = overrun_q;
      status[STAT_FRAME_ERR]  = frame_err_q;
      status[STAT_PARITY_ERR] = parity_err_q;
   end

   // Read mux; anything other than a selected read returns zero
   always_comb begin
      readdata_d = '0;
      if (rd_en) begin
         unique case (address)
            ADDR_RXDATA:   readdata_d = fifo_empty ? 32'd0 : {24'd0, fifo_dout};
            ADDR_STATUS:   readdata_d = {{(32 - STAT_W){1'b0}}, status};
            ADDR_BAUD_DIV: readdata_d = {16'd0, baud_div_q};
            ADDR_CTRL:     readdata_d = {30'd0, ctrl_q};
            default:       readdata_d = '0;
         endcase
      end
   end

   // Synchroniser, tick counter and FSM state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         baud_cnt_q <= BAUD_DIV_RST;
         state_q    <= S_IDLE;
         phase_q    <= 4'd0;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'd0;
      end else begin
         rx_meta_q  <= rx_meta_d;
         rx_sync_q  <= rx_sync_d;
         rx_prev_q  <= rx_prev_d;
         baud_cnt_q <= baud_cnt_d;
         state_q    <= state_d;
         phase_q    <= phase_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
      end
   end

   // Control, flag and read-data registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         baud_div_q   <= BAUD_DIV_RST;
         ctrl_q       <= 2'd0;
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         readdata_q   <= 32'd0;
      end else begin
         baud_div_q   <= baud_div_d;
         ctrl_q       <= ctrl_d;
         overrun_q    <= overrun_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         readdata_q   <= readdata_d;
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (rx_push),
      .din     (shift_q),
      .pop     (pop),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign readdata = readdata_q;
   assign irq      = (ctrl_q[0] & ~fifo_empty)
                   | (ctrl_q[1] & (overrun_q | frame_err_q | parity_err_q));

endmodule
